// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic: DEPTH cascaded 2-entry skid-buffer stages carrying a
// WIDTH-bit payload over valid/ready handshakes. Each stage registers its
// ready (ready = skid empty), so backpressure never forms a combinational
// path from out_ready back to in_ready. Sustains one beat per cycle and
// buffers up to 2*DEPTH beats.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (highest priority)
//   flush      synchronous discard of every buffered beat
//   in_valid   upstream beat present
//   in_ready   chain can accept a beat (registered)
//   in_data    upstream payload
//   out_valid  beat available downstream (last-stage main register)
//   out_ready  downstream accepts
//   out_data   downstream payload (last-stage main register)
//   count      beats currently buffered, 0..2*DEPTH (registered)
module pipe_reg_elastic #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 1,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [$clog2(2*DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(2*DEPTH+1);

  // Per-stage views used to stitch the chain together.
  logic             stage_valid [DEPTH];  // main register valid (stage output)
  logic [WIDTH-1:0] stage_data  [DEPTH];  // main register payload
  logic             stage_full  [DEPTH];  // skid occupied => stage not ready
  logic             up_valid    [DEPTH];  // valid offered to stage input
  logic [WIDTH-1:0] up_data     [DEPTH];
  logic             dn_ready    [DEPTH];  // ready seen at stage output

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             m_valid_reg;
      logic [WIDTH-1:0] m_data_reg;
      logic             s_valid_reg;
      logic [WIDTH-1:0] s_data_reg;
      logic             acc;
      logic             pop;

      if (gi == 0) begin : g_head
        assign up_valid[gi] = in_valid;
        assign up_data[gi]  = in_data;
      end else begin : g_link
        assign up_valid[gi] = stage_valid[gi-1];
        assign up_data[gi]  = stage_data[gi-1];
      end

      if (gi == DEPTH-1) begin : g_tail
        assign dn_ready[gi] = out_ready;
      end else begin : g_next
        assign dn_ready[gi] = ~stage_full[gi+1];
      end

      assign acc = up_valid[gi] & ~s_valid_reg;
      assign pop = m_valid_reg & dn_ready[gi];

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          m_valid_reg <= 1'b0;
          s_valid_reg <= 1'b0;
          if (CLEAR_DATA) begin
            m_data_reg <= '0;
            s_data_reg <= '0;
          end
        end else if (!m_valid_reg || pop) begin
          // Main slot frees up: drain the skid first to keep order.
          if (s_valid_reg) begin
            m_valid_reg <= 1'b1;
            m_data_reg  <= s_data_reg;
            s_valid_reg <= 1'b0;
          end else if (acc) begin
            m_valid_reg <= 1'b1;
            m_data_reg  <= up_data[gi];
          end else begin
            m_valid_reg <= 1'b0;
          end
        end else if (acc) begin
          // Main is stalled: park the incoming beat in the skid. acc already
          // implies the skid is empty, so nothing is overwritten.
          s_valid_reg <= 1'b1;
          s_data_reg  <= up_data[gi];
        end
      end

      assign stage_valid[gi] = m_valid_reg;
      assign stage_data[gi]  = m_data_reg;
      assign stage_full[gi]  = s_valid_reg;
    end
  endgenerate

  assign in_ready  = ~stage_full[0];
  assign out_valid = stage_valid[DEPTH-1];
  assign out_data  = stage_data[DEPTH-1];

  // Occupancy counter tracks chain-level handshakes only.
  logic          in_fire;
  logic          out_fire;
  logic [CW-1:0] count_reg;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_reg <= '0;
    end else if (in_fire && !out_fire) begin
      count_reg <= count_reg + CW'(1);
    end else if (out_fire && !in_fire) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic. Five instances share one stimulus stream
// (DEPTH 1,2,3,4 with cleared payload, plus DEPTH 1 with payload retained).
// A per-instance scoreboard queue records accepted beats and a negedge
// monitor pops/compares on every delivered beat; directed phases add
// latency, capacity, flush and reset checks on the relevant instance.
module tb_pipe_reg_elastic;

  localparam int NI = 5;
  localparam int DEP [NI] = '{1, 2, 3, 4, 1};

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;

  logic        ir [NI];
  logic        ov [NI];
  logic [31:0] od [NI];
  logic [31:0] count_a [NI];

  logic [1:0] cnt0;
  logic [2:0] cnt1;
  logic [2:0] cnt2;
  logic [3:0] cnt3;
  logic [1:0] cnt4;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit verbose = 1'b0;

  logic [31:0] sb [NI][$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  pipe_reg_elastic #(.WIDTH(32), .DEPTH(1), .CLEAR_DATA(1'b1)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .count(cnt0));
  pipe_reg_elastic #(.WIDTH(32), .DEPTH(2), .CLEAR_DATA(1'b1)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .count(cnt1));
  pipe_reg_elastic #(.WIDTH(32), .DEPTH(3), .CLEAR_DATA(1'b1)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .count(cnt2));
  pipe_reg_elastic #(.WIDTH(32), .DEPTH(4), .CLEAR_DATA(1'b1)) u_d4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[3]),
    .in_data(in_data), .out_valid(ov[3]), .out_ready(out_ready), .out_data(od[3]), .count(cnt3));
  pipe_reg_elastic #(.WIDTH(32), .DEPTH(1), .CLEAR_DATA(1'b0)) u_dc (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[4]),
    .in_data(in_data), .out_valid(ov[4]), .out_ready(out_ready), .out_data(od[4]), .count(cnt4));

  assign count_a[0] = 32'(cnt0);
  assign count_a[1] = 32'(cnt1);
  assign count_a[2] = 32'(cnt2);
  assign count_a[3] = 32'(cnt3);
  assign count_a[4] = 32'(cnt4);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard monitor: the reference is simply a FIFO of accepted beats,
  // emptied by rst/flush after any beat delivered in that same cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int j = 0; j < NI; j++) begin
        chk("count_vs_model", count_a[j], 32'(sb[j].size()));
        if (sb[j].size() == 0) begin
          chk("no_valid_when_empty", {31'b0, ov[j]}, 32'd0);
          chk("ready_when_empty", {31'b0, ir[j]}, 32'd1);
        end
        if (sb[j].size() == 2*DEP[j])
          chk("stall_when_full", {31'b0, ir[j]}, 32'd0);
        if (ov[j] && out_ready && !rst && sb[j].size() != 0) begin
          mon_exp = sb[j].pop_front();
          chk("order", od[j], mon_exp);
          if (verbose) $display("inst %0d deliver 0x%08h (expected 0x%08h)", j, od[j], mon_exp);
        end
        if (rst || flush) begin
          sb[j].delete();
        end else if (in_valid && ir[j]) begin
          sb[j].push_back(in_data);
          if (verbose) $display("inst %0d accept  0x%08h", j, in_data);
        end
      end
    end
  end

  initial begin
    int idx;
    int outidx;
    bit acc;
    logic ir_snap [NI];

    do_reset();
    for (int j = 0; j < NI; j++) begin
      chk("reset_out_valid", {31'b0, ov[j]}, 32'd0);
      chk("reset_in_ready", {31'b0, ir[j]}, 32'd1);
      chk("reset_count", count_a[j], 32'd0);
      if (j != 4) chk("reset_out_data", od[j], 32'd0);
    end
    mon_en = 1'b1;
    verbose = 1'b1;

    // Streaming latency and throughput on DEPTH=3.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = (i < 16);
      in_data  = 32'(i + 1);
      if (i >= 1 && i <= 2) chk("t1_latency_low", {31'b0, ov[2]}, 32'd0);
      if (i >= 3 && i <= 18) begin
        chk("t1_valid", {31'b0, ov[2]}, 32'd1);
        chk("t1_data", od[2], 32'(i - 2));
      end
      if (i >= 3 && i <= 16) chk("t1_count", count_a[2], 32'd3);
      tick();
    end

    // Capacity and backpressure release on DEPTH=2.
    do_reset();
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + 32'(idx);
      acc = ir[1];
      tick();
      if (acc) idx++;
    end
    chk("t2_accepted", 32'(idx), 32'd4);
    chk("t2_ready_low", {31'b0, ir[1]}, 32'd0);
    chk("t2_count", count_a[1], 32'd4);
    out_ready = 1'b1;
    outidx = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = (idx < 8);
      in_data  = 32'hA0 + 32'(idx);
      if (c <= 1) chk("t2_ready_hold", {31'b0, ir[1]}, 32'd0);
      if (ov[1]) begin
        chk("t2_out_seq", od[1], 32'hA0 + 32'(outidx));
        outidx++;
      end
      acc = in_valid && ir[1];
      tick();
      if (acc) idx++;
    end
    chk("t2_all_out", 32'(outidx), 32'd8);

    // Flush with a full DEPTH=2 chain: only the head beat survives.
    do_reset();
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = 32'h11 + 32'(idx);
      acc = ir[1];
      tick();
      if (acc) idx++;
    end
    chk("t4_filled", 32'(idx), 32'd4);
    in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b1; flush = 1'b1;
    chk("t4_head_valid", {31'b0, ov[1]}, 32'd1);
    chk("t4_head_data", od[1], 32'h11);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_count", count_a[1], 32'd0);
    chk("t4_out_valid", {31'b0, ov[1]}, 32'd0);
    chk("t4_in_ready", {31'b0, ir[1]}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      chk("t4_no_survivor", {31'b0, ov[1]}, 32'd0);
      tick();
    end

    // Reset with a full DEPTH=3 chain, then a fresh beat.
    do_reset();
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = 1'b1;
      in_data  = 32'h30 + 32'(idx);
      acc = ir[2];
      tick();
      if (acc) idx++;
    end
    chk("t5_filled", 32'(idx), 32'd6);
    rst = 1'b1; in_data = 32'h77;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("t5_out_valid", {31'b0, ov[2]}, 32'd0);
    chk("t5_out_data", od[2], 32'd0);
    chk("t5_count", count_a[2], 32'd0);
    chk("t5_in_ready", {31'b0, ir[2]}, 32'd1);
    in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 1 || c == 2) chk("t5_latency_low", {31'b0, ov[2]}, 32'd0);
      if (c == 3) begin
        chk("t5_new_valid", {31'b0, ov[2]}, 32'd1);
        chk("t5_new_data", od[2], 32'h55);
      end
      tick();
      in_valid = 1'b0;
    end

    // Payload retention across flush when CLEAR_DATA=0.
    do_reset();
    in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t6_delivered_valid", {31'b0, ov[4]}, 32'd1);
    chk("t6_delivered_data", od[4], 32'hDEADBEEF);
    tick();
    chk("t6_idle_valid", {31'b0, ov[4]}, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t6_flush_valid", {31'b0, ov[4]}, 32'd0);
    chk("t6_retained_data", od[4], 32'hDEADBEEF);
    chk("t6_cleared_data", od[0], 32'd0);

    // Random traffic on all instances with a probe for combinational ready.
    verbose = 1'b0;
    do_reset();
    for (int c = 0; c < 25000; c++) begin
      in_valid  = 1'($urandom_range(1, 0));
      in_data   = $urandom;
      out_ready = 1'($urandom_range(1, 0));
      #1;
      for (int j = 0; j < NI; j++) ir_snap[j] = ir[j];
      out_ready = ~out_ready;
      #1;
      for (int j = 0; j < NI; j++) chk("ready_no_comb", {31'b0, ir[j]}, {31'b0, ir_snap[j]});
      out_ready = ~out_ready;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    for (int j = 0; j < NI; j++) chk("drained", count_a[j], 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
